// File: rtl/atan_pkg.sv
// Shared constants, octant encoding and the octant fold for the arctangent datapath.
// Pure declarations: no storage, no latency.
// Not applicable: no handshake lives here.
package atan_pkg;

    localparam int PHASE_W = 16;
    localparam int Z_W     = 16;
    localparam int MULP_W  = 23;
    localparam int OCT_W   = 3;
    localparam int PROD_W  = MULP_W + Z_W;

    // Octant bit positions as produced by the upstream magnitude compare.
    localparam int OCT_SWAP = 2;
    localparam int OCT_NEGX = 1;
    localparam int OCT_NEGY = 0;

    localparam logic [PHASE_W-1:0] PHASE_EIGHTH  = 16'h2000;
    localparam logic [PHASE_W-1:0] PHASE_QUARTER = 16'h4000;
    localparam logic [PHASE_W-1:0] PHASE_HALF    = 16'h8000;

    // Coefficient B in Q0.23 turns, approximately 1/(2*pi).
    localparam logic [MULP_W-1:0] COEF_B_DEFAULT = 23'h145F30;

    // Sample travelling alongside the external A*z^2 multiplier.
    typedef struct packed {
        logic              vld;
        logic [OCT_W-1:0]  oct;
        logic [Z_W-1:0]    z;
    } dl_t;

    // Map a first-octant angle onto the full circle.
    function automatic logic [PHASE_W-1:0] fold_octant(
        input logic [PHASE_W-1:0] a_in,
        input logic [OCT_W-1:0]   oct
    );
        logic [PHASE_W-1:0] a;
        // The polynomial can overshoot slightly near z = 1; never leave the octant.
        a = (a_in > PHASE_EIGHTH) ? PHASE_EIGHTH : a_in;
        if (oct[OCT_SWAP]) a = PHASE_QUARTER - a;
        if (oct[OCT_NEGX]) a = PHASE_HALF - a;
        if (oct[OCT_NEGY]) a = {PHASE_W{1'b0}} - a;
        return a;
    endfunction

endpackage

// File: rtl/atan_delay_line.sv
// Fixed-depth shift register used to align side-band data with an external pipeline.
// Latency: DEPTH cycles.
// No backpressure: shifts every cycle; synchronous reset clears every stage.
module atan_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/atan_poly_eval.sv
// Arctangent back end: t = B - A*z^2 (clamped), P = t*z, fold octant into a 16-bit phase.
// Latency: MUL_LAT + 3 cycles from in_valid to out_valid; one sample per cycle.
// No backpressure; optional round-half-up of the phase under ATAN_ROUND_EN.
module atan_poly_eval
    import atan_pkg::*;
#(
    parameter int                MUL_LAT = 3,
    parameter logic [MULP_W-1:0] COEF_B  = COEF_B_DEFAULT
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [Z_W-1:0]     z,
    input  logic [OCT_W-1:0]   octant,
    input  logic [MULP_W-1:0]  mul_A_p,
    output logic               out_valid,
    output logic [PHASE_W-1:0] phase
);

    // Rounding needs one bit below the phase LSB; truncation does not keep it.
`ifdef ATAN_ROUND_EN
    localparam int PHI_W = PHASE_W + 1;
`else
    localparam int PHI_W = PHASE_W;
`endif
    localparam int PHI_SH = PROD_W - PHI_W;

    dl_t w_dl_in;
    dl_t w_dl_out;

    assign w_dl_in.vld = in_valid;
    assign w_dl_in.oct = octant;
    assign w_dl_in.z   = z;

    // z/octant/valid wait here while the external multiplier forms A*z^2.
    atan_delay_line #(
        .WIDTH ($bits(dl_t)),
        .DEPTH (MUL_LAT)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .i_dat (w_dl_in),
        .o_dat (w_dl_out)
    );

    // S1: subtract, clamping at zero instead of wrapping.
    logic [MULP_W-1:0] w_t;
    assign w_t = (mul_A_p > COEF_B) ? '0 : (COEF_B - mul_A_p);

    logic              r_s1_vld;
    logic [OCT_W-1:0]  r_s1_oct;
    logic [Z_W-1:0]    r_s1_z;
    logic [MULP_W-1:0] r_s1_t;

    // Register t; mul_A_p is only looked at when the aligned valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_oct <= '0;
            r_s1_z   <= '0;
            r_s1_t   <= '0;
        end else begin
            r_s1_vld <= w_dl_out.vld;
            if (w_dl_out.vld) begin
                r_s1_oct <= w_dl_out.oct;
                r_s1_z   <= w_dl_out.z;
                r_s1_t   <= w_t;
            end
        end
    end

    // S2: full 39-bit product, of which only the phase bits (plus round bit) are kept.
    logic [PHI_W-1:0] w_p_hi;
    assign w_p_hi = PHI_W'((PROD_W'(r_s1_t) * PROD_W'(r_s1_z)) >> PHI_SH);

    logic             r_s2_vld;
    logic [OCT_W-1:0] r_s2_oct;
    logic [PHI_W-1:0] r_s2_p_hi;

    // Register the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_oct  <= '0;
            r_s2_p_hi <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_oct  <= r_s1_oct;
                r_s2_p_hi <= w_p_hi;
            end
        end
    end

    // S3: first-octant angle, optionally rounded with saturation at 0xFFFF.
    logic [PHASE_W-1:0] w_a;
`ifdef ATAN_ROUND_EN
    logic [PHASE_W:0] w_a_sum;
    assign w_a_sum = {1'b0, r_s2_p_hi[PHI_W-1:1]} + {{PHASE_W{1'b0}}, r_s2_p_hi[0]};
    assign w_a     = w_a_sum[PHASE_W] ? {PHASE_W{1'b1}} : w_a_sum[PHASE_W-1:0];
`else
    assign w_a = r_s2_p_hi;
`endif

    logic               r_out_vld;
    logic [PHASE_W-1:0] r_phase;

    // Fold and register the output; phase holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_phase   <= '0;
        end else begin
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_phase <= fold_octant(w_a, r_s2_oct);
            end
        end
    end

    assign out_valid = r_out_vld;
    assign phase     = r_phase;

endmodule

// File: tb/tb_atan_poly_eval.sv
// Self-checking bench: three DUTs (MUL_LAT = 1, 3, 5) share one stimulus stream,
// each fed mul_A_p through its own model of the external multiplier pipeline.
// Scoreboard expectations come from a plain-arithmetic model of the phase rules.
module tb_atan_poly_eval;

    localparam int          NI       = 3;
    localparam int          LATS [NI] = '{1, 3, 5};
    localparam longint      REF_B    = 64'h145F30;
    localparam longint      REF_A    = 64'h0A2000;
    localparam int          PERIOD   = 10;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] z_in;
    logic [2:0]  oct_in;
    logic [22:0] mul_in;

    logic        o_vld [NI];
    logic [15:0] o_ph  [NI];

    int checks;
    int failures;

    logic [15:0] exp_ph  [NI][$];
    time         exp_t   [NI][$];
    logic [15:0] last_ph [NI];

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = LATS[g];
        logic [22:0] mpipe [L];

        // External multiplier: value issued with a sample appears L cycles later.
        always @(posedge clk) begin
            mpipe[0] <= mul_in;
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end

        atan_poly_eval #(.MUL_LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .z         (z_in),
            .octant    (oct_in),
            .mul_A_p   (mpipe[L-1]),
            .out_valid (o_vld[g]),
            .phase     (o_ph[g])
        );
    end

    // Reference phase straight from the arithmetic rules.
    function automatic logic [15:0] ref_phase(input logic [15:0] zz, input logic [2:0] oo,
                                              input logic [22:0] mm);
        longint t, p, a;
        logic [63:0] r;
        t = (longint'(mm) > REF_B) ? 0 : REF_B - longint'(mm);
        p = t * longint'(zz);
        a = p / (64'sd1 << 23);
`ifdef ATAN_ROUND_EN
        a = a + ((p / (64'sd1 << 22)) % 2);
        if (a > 65535) a = 65535;
`endif
        if (a > 8192) a = 8192;
        if (oo[2]) a = 16384 - a;
        if (oo[1]) a = 32768 - a;
        if (oo[0]) a = -a;
        a = ((a % 65536) + 65536) % 65536;
        r = a;
        return r[15:0];
    endfunction

    // A*z^2 in Q0.23 as an external multiplier would deliver it.
    function automatic logic [22:0] ext_mul(input logic [15:0] zz);
        longint m;
        logic [63:0] r;
        m = (REF_A * longint'(zz) * longint'(zz)) / (64'sd1 << 32);
        r = m;
        return r[22:0];
    endfunction

    // One clock cycle: apply inputs, track accepted samples, then score outputs.
    task automatic tick(input logic v, input logic [15:0] zz, input logic [2:0] oo,
                        input logic [22:0] mm);
        logic        has;
        logic [15:0] e;
        time         et;
        in_valid = v;
        z_in     = zz;
        oct_in   = oo;
        mul_in   = mm;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                exp_ph[k].delete();
                exp_t[k].delete();
                last_ph[k] = 16'h0000;
            end else if (v) begin
                exp_ph[k].push_back(ref_phase(zz, oo, mm));
                exp_t[k].push_back($time + (LATS[k] + 2) * PERIOD + PERIOD/2);
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (o_vld[k] === 1'b1) begin
                has = (exp_ph[k].size() > 0);
                checks++;
                assert (has === 1'b1) else begin
                    failures++;
                    $error("FAIL unexpected_out_valid lat=%0d observed=1 expected=0", LATS[k]);
                end
                if (has) begin
                    e  = exp_ph[k].pop_front();
                    et = exp_t[k].pop_front();
                    checks++;
                    assert (o_ph[k] === e) else begin
                        failures++;
                        $error("FAIL phase lat=%0d observed=%h expected=%h", LATS[k], o_ph[k], e);
                    end
                    checks++;
                    assert ($time === et) else begin
                        failures++;
                        $error("FAIL latency lat=%0d observed_t=%0t expected_t=%0t", LATS[k], $time, et);
                    end
                end
            end else begin
                checks++;
                assert (o_vld[k] === 1'b0 && o_ph[k] === last_ph[k]) else begin
                    failures++;
                    $error("FAIL idle_hold lat=%0d observed=%b/%h expected=0/%h",
                           LATS[k], o_vld[k], o_ph[k], last_ph[k]);
                end
            end
            last_ph[k] = o_ph[k];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'($urandom), 3'($urandom), 23'($urandom));
    endtask

    task automatic check_const(input string tag, input logic [15:0] e);
        for (int k = 0; k < NI; k++) begin
            checks++;
            assert (o_ph[k] === e) else begin
                failures++;
                $error("FAIL %s lat=%0d observed=%h expected=%h", tag, LATS[k], o_ph[k], e);
            end
        end
    endtask

    // Single sample, let it drain, then compare the held phase against a constant.
    task automatic run_one(input logic [15:0] zz, input logic [2:0] oo, input logic [22:0] mm,
                           input logic [15:0] e, input string tag);
        tick(1'b1, zz, oo, mm);
        idle(10);
        check_const(tag, e);
    endtask

    initial begin
        logic [15:0] zr, step;
        logic [2:0]  orr;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int k = 0; k < NI; k++) last_ph[k] = 16'h0000;
        idle(3);
        rst = 1'b0;

        // Reset state.
        check_const("reset_phase", 16'h0000);
        for (int k = 0; k < NI; k++) begin
            checks++;
            assert (o_vld[k] === 1'b0) else begin
                failures++;
                $error("FAIL reset_out_valid lat=%0d observed=%b expected=0", LATS[k], o_vld[k]);
            end
        end

        // Basic point, octant sweep, clamps.
        run_one(16'h8000, 3'b000, 23'h000000, 16'h145F, "basic");
        run_one(16'h0000, 3'b100, 23'h000000, 16'h4000, "oct_swap");
        run_one(16'h0000, 3'b010, 23'h000000, 16'h8000, "oct_negx");
        run_one(16'h0000, 3'b011, 23'h000000, 16'h8000, "oct_negxy");
        run_one(16'h0000, 3'b111, 23'h000000, 16'hC000, "oct_all");
        run_one(16'h8000, 3'b000, 23'h200000, 16'h0000, "t_clamp");
        run_one(16'hFFFF, 3'b000, 23'h000000, 16'h2000, "eighth_clamp");

        // P[22] = 1: rounding adds exactly one LSB.
`ifdef ATAN_ROUND_EN
        run_one(16'h8000, 3'b000, 23'h000080, 16'h145F, "round_bit");
`else
        run_one(16'h8000, 3'b000, 23'h000080, 16'h145E, "round_bit");
`endif

        // 20 back-to-back samples, ramping z, multiplier model feeding mul_A_p.
        zr   = 16'($urandom);
        step = 16'($urandom_range(1, 3000));
        for (int i = 0; i < 20; i++) begin
            orr = 3'($urandom);
            tick(1'b1, zr, orr, ext_mul(zr));
            zr = zr + step;
        end
        idle(10);

        // Random traffic with gaps and occasional out-of-range mul_A_p.
        for (int i = 0; i < 200; i++) begin
            zr  = 16'($urandom);
            orr = 3'($urandom);
            if ($urandom_range(0, 3) == 0) tick(1'b0, zr, orr, 23'($urandom));
            else if ($urandom_range(0, 4) == 0) tick(1'b1, zr, orr, 23'($urandom));
            else tick(1'b1, zr, orr, ext_mul(zr));
        end
        idle(10);

        // Reset two cycles after a 4-sample burst; in_valid during reset is dropped.
        for (int i = 0; i < 4; i++) begin
            zr = 16'($urandom);
            tick(1'b1, zr, 3'($urandom), ext_mul(zr));
        end
        idle(2);
        rst = 1'b1;
        tick(1'b1, 16'h8000, 3'b000, 23'h000000);
        rst = 1'b0;
        check_const("post_reset_phase", 16'h0000);
        idle(12);
        check_const("post_reset_quiet", 16'h0000);
        run_one(16'h8000, 3'b010, 23'h000000, 16'h6BA1, "post_reset_sample");

        // Everything issued must have come out.
        idle(12);
        for (int k = 0; k < NI; k++) begin
            checks++;
            assert (exp_ph[k].size() === 0) else begin
                failures++;
                $error("FAIL drain lat=%0d observed_pending=%0d expected=0", LATS[k], exp_ph[k].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atan_poly_eval.md
# atan_poly_eval

Downstream stage of the arctangent polynomial datapath. Consumes the externally multiplied term `mul_A_p` (A·z²) and subtracts it from coefficient B. It then multiplies the result by the time-aligned ratio z and folds the octant result into a full-circle 16-bit phase word. z, octant and valid are delayed internally to match the fixed latency of the external `A·z²` multiplier, so the upstream stage issues each sample exactly once.

## Interface
Parameters:
- `MUL_LAT`, default 3: cycles from `in_valid`/`z` to the matching `mul_A_p` (external multiplier latency, ≥1).
- `COEF_B`, default 23'h145F30: coefficient B in Q0.23 turns (≈1/2π).

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: z/octant sample valid this cycle.
- `z`, input, 16: ratio min/max, unsigned Q0.16, same value whose square feeds the multiplier.
- `octant`, input, 3: bit2 = swap (|y|>|x|), bit1 = neg_x, bit0 = neg_y.
- `mul_A_p`, input, 23: A·z² in Q0.23. Sampled exactly `MUL_LAT` cycles after the matching `in_valid`.
- `out_valid`, output, 1: phase valid.
- `phase`, output, 16: angle in turns, full circle = 2^16, unsigned modulo.

## Operation
- Delay line: `z`, `octant` and `in_valid` are shifted through `MUL_LAT` registers. The delayed valid qualifies `mul_A_p`; `mul_A_p` is ignored whenever the delayed valid is 0.
- S1 (sub): t = COEF_B − mul_A_p, 23-bit unsigned. If mul_A_p > COEF_B, t = 0 (clamp, no wrap).
- S2 (mul): P = t × z_d, 39-bit unsigned, registered.
- S3 (fold):
  - a = P[38:23], plus rounding (see Configuration).
  - If a > 16'h2000, a = 16'h2000 (clamp to 1/8 turn).
  - If swap: a = 16'h4000 − a.
  - If neg_x: a = 16'h8000 − a.
  - If neg_y: a = −a (mod 2^16).
  - All fold arithmetic is 16-bit with natural wrap.
- No backpressure. One result per accepted sample, in order. Back-to-back `in_valid` is supported every cycle.

## Timing
- Latency: `in_valid` at cycle n → `out_valid` at cycle n + `MUL_LAT` + 3. Throughput is 1 sample/cycle.
- `out_valid` is high for exactly one cycle per input sample. `phase` holds its last value while `out_valid` = 0.
- Reset values: `out_valid` = 0, `phase` = 16'h0000, all delay-line and pipeline valids = 0. Data registers are also cleared to 0.
- Reset mid-operation: all in-flight samples are dropped, and no `out_valid` results from samples accepted before reset. `mul_A_p` values arriving after reset for pre-reset samples are ignored.
- `in_valid` asserted in the same cycle as `rst`: the sample is dropped.

## Configuration
- `ATAN_ROUND_EN` defined: a = P[38:23] + P[22] (round half up). The result saturates at 16'hFFFF before the 1/8-turn clamp, so it never wraps.
- `ATAN_ROUND_EN` not defined: a = P[38:23] (truncate). No extra adder.
- Latency is identical with and without the macro.

## Structure
- Shared package `atan_pkg`:
  - `PHASE_W` = 16, `Z_W` = 16, `MULP_W` = 23.
  - Octant bit indices `OCT_SWAP`/`OCT_NEGX`/`OCT_NEGY`.
  - Constants `PHASE_EIGHTH` = 16'h2000, `PHASE_QUARTER` = 16'h4000, `PHASE_HALF` = 16'h8000.
  - `COEF_B` default.
- Sub-module `atan_delay_line` (parameters WIDTH, DEPTH; synchronous reset clears contents). It is instantiated once for {valid, octant, z}.

## Test plan
1. mul_A_p = 0, z = 16'h8000, octant = 3'b000 → phase = 16'h145F at cycle n+MUL_LAT+3, `out_valid` for 1 cycle.
2. z = 16'h0000, octant sweep 3'b100 / 3'b010 / 3'b011 / 3'b111 → phase 16'h4000 / 16'h8000 / 16'h8000 / 16'hC000.
3. mul_A_p = 23'h200000 (> COEF_B), z = 16'h8000, octant 000 → phase 16'h0000 (t clamped). mul_A_p = 0, z = 16'hFFFF → phase 16'h2000 (1/8-turn clamp).
4. `in_valid` high 20 consecutive cycles with a ramping z, with mul_A_p driven from a model of the external multiplier at `MUL_LAT` → 20 consecutive in-order `out_valid` pulses matching the model. Repeat with `MUL_LAT` = 1 and 5.
5. Reset asserted 2 cycles after a 4-sample burst, held 1 cycle → no `out_valid` for those samples. `phase` = 0 after reset, and a fresh sample afterwards produces a correct result.
6. With and without `ATAN_ROUND_EN`, t chosen so that P[22] = 1 → phase differs by exactly 1 LSB, with latency unchanged.
